// File: rtl/slicem_cfg_pkg.sv
// Shared types and size helpers for the slice config loader.
// Optional parity-word checking is selected with the CFG_PARITY_EN macro in the loader.
package slicem_cfg_pkg;

  localparam int DEF_S_XX_BASE = 4;
  localparam int DEF_CFG_SIZE  = 2**DEF_S_XX_BASE + 1;
  localparam int DEF_NUM_LUTS  = 4;
  localparam int DEF_WORD_W    = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FILL   = 3'd1,
    ST_COMMIT = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERR    = 3'd4
  } state_t;

  // One frame = every LUT's two halves plus the trailing use_cc bit.
  function automatic int frame_bits(input int cfg_size, input int num_luts);
    return num_luts * 2 * cfg_size + 1;
  endfunction

  function automatic int num_words(input int fb, input int word_w);
    return (fb + word_w - 1) / word_w;
  endfunction

  function automatic int cnt_width(input int nw);
    return $clog2(nw + 1);
  endfunction

endpackage

// File: rtl/slicem_cfg_loader.sv
// Streams a slice config frame into a shadow register, commits it and pulses cen.
// Define CFG_PARITY_EN to require a trailing XOR parity word per frame.
module slicem_cfg_loader
  import slicem_cfg_pkg::*;
#(
  parameter int S_XX_BASE = 4,
  parameter int CFG_SIZE  = 2**S_XX_BASE + 1,
  parameter int NUM_LUTS  = 4,
  parameter int WORD_W    = 8
) (
  input  logic                                  cclk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic [WORD_W-1:0]                     cfg_word,
  input  logic                                  cfg_valid,
  output logic                                  cfg_ready,
  output logic [NUM_LUTS-1:0][2*CFG_SIZE-1:0]   luts_config_out,
  output logic                                  use_cc_out,
  output logic                                  cen,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  err
);

  localparam int LUT_W      = 2 * CFG_SIZE;
  localparam int FRAME_BITS = frame_bits(CFG_SIZE, NUM_LUTS);
  localparam int NUM_WORDS  = num_words(FRAME_BITS, WORD_W);
  localparam int CW         = cnt_width(NUM_WORDS);

  state_t                              state_q, state_d;
  logic [CW-1:0]                       cnt_q, cnt_d;
  logic [FRAME_BITS-1:0]               shadow_q, shadow_d;
  logic [NUM_LUTS-1:0][LUT_W-1:0]      luts_q, luts_d;
  logic                                use_cc_q, use_cc_d;
  logic                                wr_word;
  logic                                load_out;
`ifdef CFG_PARITY_EN
  logic [WORD_W-1:0]                   parity_q, parity_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    luts_d   = luts_q;
    use_cc_d = use_cc_q;
    wr_word  = 1'b0;
    load_out = 1'b0;
`ifdef CFG_PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d = ST_FILL;
          cnt_d   = '0;
`ifdef CFG_PARITY_EN
          parity_d = '0;
`endif
        end
      end
      ST_FILL: begin
        if (cfg_valid) begin
`ifdef CFG_PARITY_EN
          if (cnt_q == CW'(NUM_WORDS)) begin
            // Shadow is already complete; the extra word only gates the commit.
            if (cfg_word == parity_q) begin
              state_d  = ST_COMMIT;
              load_out = 1'b1;
            end else begin
              state_d = ST_ERR;
            end
          end else begin
            wr_word  = 1'b1;
            parity_d = parity_q ^ cfg_word;
            cnt_d    = cnt_q + 1'b1;
          end
`else
          wr_word = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CW'(NUM_WORDS - 1)) begin
            state_d  = ST_COMMIT;
            load_out = 1'b1;
          end
`endif
        end
      end
      ST_COMMIT: state_d = ST_DONE;
      default:   state_d = ST_IDLE;
    endcase

    // Pad bits past the frame end simply have no shadow bit to land in.
    if (wr_word) begin
      for (int w = 0; w < NUM_WORDS; w++) begin
        if (cnt_q == CW'(w)) begin
          for (int b = 0; b < WORD_W; b++) begin
            if (w * WORD_W + b < FRAME_BITS) shadow_d[w*WORD_W+b] = cfg_word[b];
          end
        end
      end
    end

    // Loading from shadow_d lets the final data word reach the outputs in the cen cycle.
    if (load_out) begin
      for (int k = 0; k < NUM_LUTS; k++) luts_d[k] = shadow_d[k*LUT_W +: LUT_W];
      use_cc_d = shadow_d[FRAME_BITS-1];
    end
  end

  always_ff @(posedge cclk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      luts_q   <= '0;
      use_cc_q <= 1'b0;
`ifdef CFG_PARITY_EN
      parity_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      luts_q   <= luts_d;
      use_cc_q <= use_cc_d;
`ifdef CFG_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign cfg_ready       = (state_q == ST_FILL);
  assign cen             = (state_q == ST_COMMIT);
  assign busy            = (state_q == ST_FILL) || (state_q == ST_COMMIT);
  assign done            = (state_q == ST_DONE);
  assign luts_config_out = luts_q;
  assign use_cc_out      = use_cc_q;
`ifdef CFG_PARITY_EN
  assign err = (state_q == ST_ERR);
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_slicem_cfg_loader.sv
// Self-checking bench for slicem_cfg_loader; also exercises parity when CFG_PARITY_EN is defined.
module tb_slicem_cfg_loader;

  localparam int FB  = 4 * 2 * 17 + 1;
  localparam int NW  = (FB + 7) / 8;
  localparam int LW  = 34;
`ifdef CFG_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic              cclk = 1'b0;
  logic              rst_n, start, cfg_valid;
  logic [7:0]        cfg_word;
  logic              cfg_ready, use_cc_out, cen, busy, done, err;
  logic [3:0][33:0]  luts_config_out;

  slicem_cfg_loader dut (
    .cclk(cclk), .rst_n(rst_n), .start(start), .cfg_word(cfg_word),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .luts_config_out(luts_config_out),
    .use_cc_out(use_cc_out), .cen(cen), .busy(busy), .done(done), .err(err)
  );

  always #5 cclk = ~cclk;

  int           n_asserts = 0;
  int           n_fails   = 0;
  logic [7:0]   tx_words [NW];
  logic [135:0] held_luts = '0;
  logic         held_cc   = 1'b0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference frame: word n bit b is frame bit 8n+b; LUT k is the k-th 34-bit slice.
  function automatic logic [FB-1:0] ref_frame();
    logic [FB-1:0] f;
    for (int i = 0; i < FB; i++) f[i] = tx_words[i / 8][i % 8];
    return f;
  endfunction

  function automatic logic [7:0] ref_parity();
    logic [7:0] p = '0;
    for (int n = 0; n < NW; n++) p ^= tx_words[n];
    return p;
  endfunction

  // mode: 0 valid held high, 1 valid every other cycle, 2 random valid
  task automatic run_load(input string tag, input int mode, input bit poke_start,
                          input bit force_par, input logic [7:0] par_word);
    int hs = 0, cyc = 0, cens = 0, rdy = 0, total;
    bit hold_ok = 1'b1, v, took, par_ok;
    logic [FB-1:0] f;
    logic [7:0] pw;
    total = NW + (PAR_EN ? 1 : 0);
    pw = force_par ? par_word : ref_parity();
    @(negedge cclk); start = 1'b1;
    @(negedge cclk); start = 1'b0;
    while (hs < total && cyc < 500) begin
      v = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      cfg_valid = v;
      cfg_word  = (hs < NW) ? tx_words[hs] : pw;
      start     = (poke_start && cyc == 3);
      if (cfg_ready) rdy++;
      if (cen) cens++;
      if (luts_config_out !== held_luts || use_cc_out !== held_cc) hold_ok = 1'b0;
      took = cfg_ready && v;
      @(negedge cclk);
      if (took) hs++;
      cyc++;
    end
    cfg_valid = 1'b0;
    start = 1'b0;
    chk({tag, "_budget"}, 256'(hs), 256'(total));
    chk({tag, "_no_early_cen"}, 256'(cens), 256'd0);
    chk({tag, "_hold_during_fill"}, 256'(hold_ok), 256'd1);
    if (mode == 0) chk({tag, "_ready_cycles"}, 256'(rdy), 256'(total));
    f = ref_frame();
    par_ok = !PAR_EN || (pw == ref_parity());
    if (par_ok) begin
      held_luts = f[135:0];
      held_cc   = f[FB-1];
    end
    chk({tag, "_cen"}, 256'(cen), 256'(par_ok));
    chk({tag, "_err"}, 256'(err), 256'(!par_ok));
    chk({tag, "_luts"}, 256'(luts_config_out), 256'(held_luts));
    chk({tag, "_use_cc"}, 256'(use_cc_out), 256'(held_cc));
    $display("load %s: mode=%0d handshakes=%0d cycles=%0d parity_ok=%0d", tag, mode, hs, cyc, par_ok);
    @(negedge cclk);
    chk({tag, "_cen_single"}, 256'(cen), 256'd0);
    chk({tag, "_done"}, 256'(done), 256'(par_ok));
    chk({tag, "_busy_after"}, 256'(busy), 256'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_cen"}, 256'(cen), 256'd0);
    chk({tag, "_busy"}, 256'(busy), 256'd0);
    chk({tag, "_done"}, 256'(done), 256'd0);
    chk({tag, "_ready"}, 256'(cfg_ready), 256'd0);
    chk({tag, "_err"}, 256'(err), 256'd0);
    chk({tag, "_luts"}, 256'(luts_config_out), 256'd0);
    chk({tag, "_use_cc"}, 256'(use_cc_out), 256'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; cfg_valid = 1'b0; cfg_word = '0;
    repeat (2) @(negedge cclk);
    chk_zero("por");
    rst_n = 1'b1;

    // Full load of 8'hA5, valid held high
    for (int n = 0; n < NW; n++) tx_words[n] = 8'hA5;
    run_load("a5_full", 0, 1'b0, 1'b0, 8'h00);
    chk("a5_lut0_const", 256'(luts_config_out[0]), 256'(34'h1A5A5A5A5));
    chk("a5_use_cc_const", 256'(use_cc_out), 256'd1);

    // Words offered while not in FILL must be dropped
    for (int i = 0; i < 3; i++) begin
      cfg_valid = 1'b1; cfg_word = 8'($urandom);
      chk("idle_ready_low", 256'(cfg_ready), 256'd0);
      @(negedge cclk);
    end
    cfg_valid = 1'b0;
    run_load("a5_toggle", 1, 1'b0, 1'b0, 8'h00);

    // Reset after 9 words: no cen, everything back to zero
    @(negedge cclk); start = 1'b1;
    @(negedge cclk); start = 1'b0;
    cfg_valid = 1'b1;
    for (int n = 0; n < 9; n++) begin
      cfg_word = 8'hA5;
      chk("part_cen", 256'(cen), 256'd0);
      @(negedge cclk);
    end
    cfg_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge cclk); chk_zero("rst_mid1");
    @(negedge cclk); chk_zero("rst_mid2");
    rst_n = 1'b1;
    held_luts = '0; held_cc = 1'b0;
    $display("reset applied after 9 words");

    for (int n = 0; n < NW; n++) tx_words[n] = 8'h00;
    run_load("zero_rand", 2, 1'b0, 1'b0, 8'h00);

    // Reload A5, then a 3C frame with a stray start during FILL
    for (int n = 0; n < NW; n++) tx_words[n] = 8'hA5;
    run_load("a5_again", 0, 1'b0, 1'b0, 8'h00);
    for (int n = 0; n < NW; n++) tx_words[n] = 8'h3C;
    run_load("3c_poke", 1, 1'b1, 1'b0, 8'h00);
    chk("3c_lut0_const", 256'(luts_config_out[0]), 256'(34'h03C3C3C3C));

    for (int t = 0; t < 4; t++) begin
      for (int n = 0; n < NW; n++) tx_words[n] = 8'($urandom);
      run_load($sformatf("rand%0d", t), 2, t[0], 1'b0, 8'h00);
    end

`ifdef CFG_PARITY_EN
    for (int n = 0; n < NW; n++) tx_words[n] = 8'hA5;
    run_load("par_bad", 0, 1'b0, 1'b1, 8'h01);
    run_load("par_good", 0, 1'b0, 1'b1, 8'h00);
    for (int n = 0; n < NW; n++) tx_words[n] = 8'($urandom);
    run_load("par_rand_bad", 2, 1'b0, 1'b1, ref_parity() ^ 8'h80);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
